// File: rtl/hv_majority_bundler_if.sv
// Valid/ready stream carrying one D-bit hypervector per transfer.
// The bundler takes the slave side on its input and the master side on its output.
interface hv_majority_bundler_if #(
    parameter int D = 1024
) ();
    logic         valid;
    logic         ready;
    logic [D-1:0] data;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/hv_majority_bundler.sv
// Bundles N incoming hypervectors into one by per-bit majority vote.
// Ties go to the first vector of the bundle.
module hv_majority_bundler #(
    parameter int D     = 1024,
    parameter int CNT_W = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  start_i,
    input  logic [CNT_W-1:0]      count_n_i,
    hv_majority_bundler_if.slave  in_if,
    hv_majority_bundler_if.master out_if,
    output logic                  busy_o,
    output logic                  err_zero_o
);

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        THRESH,
        OUT
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q [D];
    logic [CNT_W-1:0] n_q;
    logic [CNT_W-1:0] rcv_q;
    logic [D-1:0]     first_q;
    logic [D-1:0]     out_q;
    logic             err_q, err_d;

    logic             clear;
    logic             accept;
    logic             load_out;
    logic             in_ready;
    logic             out_valid;
    logic [D-1:0]     maj_hv;

    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        clear     = 1'b0;
        accept    = 1'b0;
        load_out  = 1'b0;
        err_d     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    if (count_n_i != '0) begin
                        clear   = 1'b1;
                        state_d = ACCUM;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ACCUM: begin
                in_ready = 1'b1;
                accept   = in_if.valid;
                if (in_if.valid && ((rcv_q + CNT_W'(1)) == n_q)) begin
                    state_d = THRESH;
                end
            end
            THRESH: begin
                load_out = 1'b1;
                state_d  = OUT;
            end
            OUT: begin
                out_valid = 1'b1;
                if (out_if.ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
        end
    end

    // Doubling the count instead of halving N keeps the comparison exact at CNT_W+1 bits.
    always_comb begin
        maj_hv = '0;
        for (int i = 0; i < D; i++) begin
            logic [CNT_W:0] dbl;
            logic [CNT_W:0] nx;
            dbl = {cnt_q[i], 1'b0};
            nx  = {1'b0, n_q};
            if (dbl > nx) begin
                maj_hv[i] = 1'b1;
            end else if (dbl < nx) begin
                maj_hv[i] = 1'b0;
            end else begin
                maj_hv[i] = first_q[i];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < D; i++) begin
                cnt_q[i] <= '0;
            end
            n_q     <= '0;
            rcv_q   <= '0;
            first_q <= '0;
            out_q   <= '0;
        end else begin
            if (clear) begin
                for (int i = 0; i < D; i++) begin
                    cnt_q[i] <= '0;
                end
                rcv_q <= '0;
                n_q   <= count_n_i;
            end
            if (accept) begin
                for (int i = 0; i < D; i++) begin
                    cnt_q[i] <= cnt_q[i] + CNT_W'(in_if.data[i]);
                end
                rcv_q <= rcv_q + CNT_W'(1);
                if (rcv_q == '0) begin
                    first_q <= in_if.data;
                end
            end
            if (load_out) begin
                out_q <= maj_hv;
            end
        end
    end

    assign in_if.ready  = in_ready;
    assign out_if.valid = out_valid;
    assign out_if.data  = out_q;
    assign busy_o       = (state_q != IDLE);
    assign err_zero_o   = err_q;

endmodule

// File: tb/tb_hv_majority_bundler.sv
// Drives directed and random bundles into hv_majority_bundler and scores every output
// against a per-bit vote computed directly from the vectors that were sent.
module tb_hv_majority_bundler;

    localparam int D     = 8;
    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             rstN;
    logic             start;
    logic [CNT_W-1:0] countN;
    logic             busy;
    logic             errZero;

    hv_majority_bundler_if #(.D(D)) inIf ();
    hv_majority_bundler_if #(.D(D)) outIf ();

    hv_majority_bundler #(.D(D), .CNT_W(CNT_W)) dut (
        .clk_i      (clk),
        .rst_ni     (rstN),
        .start_i    (start),
        .count_n_i  (countN),
        .in_if      (inIf),
        .out_if     (outIf),
        .busy_o     (busy),
        .err_zero_o (errZero)
    );

    always #5 clk = ~clk;

    int           total = 0;
    int           bad   = 0;
    logic [D-1:0] expQ[$];
    logic [D-1:0] stimVecs[$];
    int           stimGaps[$];

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0h want %0h", name, actual, expected);
        end
    endtask

    // Reference vote: count ones per bit position over the whole bundle.
    function automatic logic [D-1:0] majorityOf(input int n);
        logic [D-1:0] res;
        res = '0;
        for (int b = 0; b < D; b++) begin
            int ones;
            ones = 0;
            for (int k = 0; k < n; k++) begin
                ones += int'(stimVecs[k][b]);
            end
            if (2 * ones > n)      res[b] = 1'b1;
            else if (2 * ones < n) res[b] = 1'b0;
            else                   res[b] = stimVecs[0][b];
        end
        return res;
    endfunction

    // Monitor: every presented output is scored against the oldest expected bundle.
    always @(negedge clk) begin
        if (rstN && outIf.valid) begin
            if (expQ.size() == 0) begin
                total++;
                bad++;
                $display("[TB] FAIL unexpected_out: got %0h with no bundle pending", outIf.data);
            end else begin
                checkOutput(outIf.ready ? "out_hv" : "out_hv_hold", 32'(outIf.data), 32'(expQ[0]));
                if (outIf.ready) void'(expQ.pop_front());
            end
        end
    end

    task automatic startBundle(input int n);
        @(posedge clk) #1;
        start  = 1'b1;
        countN = CNT_W'(n);
        @(posedge clk) #1;
        start  = 1'b0;
    endtask

    task automatic feedVectors(input int n, input bit checkGapReady);
        for (int i = 0; i < n; i++) begin
            bit accepted;
            repeat (stimGaps[i]) begin
                @(negedge clk);
                if (checkGapReady) checkOutput("in_ready_gap", 32'(inIf.ready), 32'd1);
                @(posedge clk) #1;
            end
            inIf.valid = 1'b1;
            inIf.data  = stimVecs[i];
            accepted   = 1'b0;
            for (int w = 0; w < 50 && !accepted; w++) begin
                @(negedge clk);
                if (inIf.ready) accepted = 1'b1;
                @(posedge clk) #1;
            end
            if (!accepted) begin
                total++;
                bad++;
                $display("[TB] FAIL accept_timeout: vector %0d not accepted, got 0 want 1", i);
            end
            inIf.valid = 1'b0;
        end
    endtask

    task automatic applyStimulus(input int n, input bit checkLat, input bit checkGapReady);
        startBundle(n);
        expQ.push_back(majorityOf(n));
        feedVectors(n, checkGapReady);
        if (checkLat) begin
            @(negedge clk);
            checkOutput("lat_thresh_valid", 32'(outIf.valid), 32'd0);
            @(negedge clk);
            checkOutput("lat_out_valid", 32'(outIf.valid), 32'd1);
        end
    endtask

    task automatic drainOutput(input int stall, input bit startDuringStall);
        bit seen;
        seen = 1'b0;
        for (int w = 0; w < 20 && !seen; w++) begin
            @(negedge clk);
            if (outIf.valid) seen = 1'b1;
        end
        if (!seen) begin
            total++;
            bad++;
            $display("[TB] FAIL out_timeout: out_valid got 0 want 1");
        end
        @(posedge clk) #1;
        for (int s = 0; s < stall; s++) begin
            start  = startDuringStall && (s == stall / 2);
            countN = 8'd3;
            @(posedge clk) #1;
        end
        start        = 1'b0;
        outIf.ready  = 1'b1;
        @(posedge clk) #1;
        outIf.ready  = 1'b0;
        @(negedge clk);
        checkOutput("busy_after_out", 32'(busy), 32'd0);
    endtask

    task automatic loadT1();
        stimVecs = '{8'hF0, 8'hCC, 8'hAA};
        stimGaps = '{0, 0, 0};
    endtask

    initial begin
        rstN        = 1'b0;
        start       = 1'b0;
        countN      = '0;
        inIf.valid  = 1'b0;
        inIf.data   = '0;
        outIf.ready = 1'b0;

        #1;
        checkOutput("rst_in_ready", 32'(inIf.ready), 32'd0);
        checkOutput("rst_out_valid", 32'(outIf.valid), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_err_zero", 32'(errZero), 32'd0);
        checkOutput("rst_out_hv", 32'(outIf.data), 32'd0);
        repeat (2) @(negedge clk);
        rstN = 1'b1;

        // T1: back-to-back with latency check; the model must give E8.
        loadT1();
        checkOutput("model_t1", 32'(majorityOf(3)), 32'hE8);
        applyStimulus(3, 1'b1, 1'b0);
        drainOutput(0, 1'b0);

        // T2: single vector passes straight through.
        stimVecs = '{8'h5A};
        stimGaps = '{0};
        applyStimulus(1, 1'b0, 1'b0);
        drainOutput(1, 1'b0);

        // T3: every bit ties, first vector wins.
        stimVecs = '{8'hF0, 8'h0F};
        stimGaps = '{0, 0};
        applyStimulus(2, 1'b0, 1'b0);
        drainOutput(0, 1'b0);

        // T4: gaps between accepts, in_ready must stay high.
        stimVecs = '{8'hF0, 8'hCC, 8'hAA};
        stimGaps = '{0, 2, 5};
        applyStimulus(3, 1'b0, 1'b1);
        drainOutput(0, 1'b0);

        // T5: long output stall with a stray start.
        loadT1();
        applyStimulus(3, 1'b0, 1'b0);
        drainOutput(10, 1'b1);
        repeat (3) @(negedge clk);
        checkOutput("start_in_out_ignored", 32'(busy), 32'd0);

        // T6: zero-length start flags an error and stays idle.
        @(posedge clk) #1;
        start  = 1'b1;
        countN = '0;
        @(posedge clk) #1;
        start  = 1'b0;
        @(negedge clk);
        checkOutput("err_zero_pulse", 32'(errZero), 32'd1);
        checkOutput("err_zero_busy", 32'(busy), 32'd0);
        @(negedge clk);
        checkOutput("err_zero_once", 32'(errZero), 32'd0);

        // T6: reset in the middle of an N=4 accumulation.
        stimVecs = '{8'h3C, 8'hFF};
        stimGaps = '{0, 0};
        startBundle(4);
        feedVectors(2, 1'b0);
        #2;
        rstN = 1'b0;
        #1;
        checkOutput("midrst_in_ready", 32'(inIf.ready), 32'd0);
        checkOutput("midrst_busy", 32'(busy), 32'd0);
        checkOutput("midrst_out_valid", 32'(outIf.valid), 32'd0);
        checkOutput("midrst_out_hv", 32'(outIf.data), 32'd0);
        @(negedge clk);
        rstN = 1'b1;
        loadT1();
        applyStimulus(3, 1'b1, 1'b0);
        drainOutput(2, 1'b0);

        // Random bundles with random gaps and output stalls.
        for (int t = 0; t < 25; t++) begin
            int n;
            n = int'($urandom_range(1, 12));
            stimVecs.delete();
            stimGaps.delete();
            for (int k = 0; k < n; k++) begin
                stimVecs.push_back(D'($urandom));
                stimGaps.push_back(int'($urandom_range(0, 3)));
            end
            applyStimulus(n, 1'b0, 1'b0);
            drainOutput(int'($urandom_range(0, 4)), 1'b0);
        end

        repeat (3) @(negedge clk);
        checkOutput("scoreboard_empty", 32'(expQ.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout: simulation did not finish, got timeout want done");
        $fatal(1, "[TB] timeout");
    end

endmodule
